stream_accept_delay: RTL and testbench
======================================

// Module: stream_accept_delay
// PURPOSE
// - Sink-side backpressure injector for valid/ready streams. Mirrors the source-side valid delay:
//   holds off the upstream handshake by a fixed or pseudo-random number of cycles per beat.
// - Sits between a stream producer and its consumer, in benches or in debug builds.
// - Flags upstream protocol violations made while it is stalling.
// PARAMETERS
// - StallRandom  0        1: per-beat delay drawn from the internal LFSR; 0: FixedDelay used
// - FixedDelay   1        per-beat delay in cycles, 0..MaxDelay; 0 with StallRandom=0 = pure wire
// - MaxDelay     15       upper bound on delay; must be 2^k-1, k in 1..8; CW = k
// - LfsrSeed     16'hACE1 LFSR reset value; must be nonzero (elaboration assertion)
// - payload_t    logic    payload type
// PORTS
// - clk_i      in   1         clock, rising edge
// - rst_ni     in   1         asynchronous reset, active low
// - payload_i  in   payload_t upstream payload
// - valid_i    in   1         upstream valid
// - ready_o    out  1         upstream ready
// - payload_o  out  payload_t downstream payload (= payload_i, combinational)
// - valid_o    out  1         downstream valid
// - ready_i    in   1         downstream ready
// - err_o      out  1         sticky protocol-violation flag
// BEHAVIOUR
// - Pass-through (FixedDelay==0 && !StallRandom):
//   - ready_o=ready_i, valid_o=valid_i; err_o tied 0; no flops.
// - Per-beat delay d: FixedDelay, or lfsr_q[CW-1:0] when StallRandom.
//   - The LFSR advances only on a load.
// - LFSR: 16-bit Fibonacci, shift left, bit0 <= q[15]^q[13]^q[12]^q[10].
// - FSM: Idle, Stall, Grant. Reset: state=Idle, cnt=0, lfsr=LfsrSeed, err_o=0.
// - Idle, valid_i=0: valid_o=0, ready_o=0.
// - Idle, valid_i=1: load=1, snapshot payload_i.
//   - d==0: valid_o=1, ready_o=ready_i; ready_i ? stay Idle : ->Grant.
//   - d==1: valid_o=0, ready_o=0, ->Grant.
//   - d>=2: valid_o=0, ready_o=0, cnt<=d-1, ->Stall.
// - Stall: valid_o=0, ready_o=0; cnt decrements; when cnt==1, ->Grant.
// - Grant: valid_o=1, ready_o=ready_i; on ready_i, ->Idle.
// - Latency: valid_o first rises exactly d cycles after valid_i first rises.
//   - Each beat pays its own d. Back-to-back beats see no bubble only when d==0.
// - Upstream ready_o is never high while valid_o is low.
//   - Each upstream handshake equals exactly one downstream handshake.
// - err_o: set the cycle after either violation, in Stall or Grant:
//   - valid_i==0, or
//   - payload_i != snapshot.
//   - Held until reset. The FSM still completes the beat on the following handshake.
//   - If valid_i drops in Grant, the FSM stays in Grant; valid_o stays 1.
// - Reset mid-beat: the beat is abandoned, FSM returns to Idle, LFSR is reseeded; no beat is replayed.
// - Simultaneous load and error in Idle: impossible by construction; checks start in Stall.
// STRUCTURE
// - Package stream_pkg: LFSR tap constant and default seed.
//   - Shared with the existing source-side delay block.
// - Local to the module: state enum (logic [1:0]), the CW-bit counter, payload snapshot register.
// - Sub-module: counter (WIDTH=CW, down_i=1, load_i=load, en_i=state==Stall, clear_i=0).
// - The LFSR is a local always_ff. Payload snapshot and error logic are absent in pass-through.
// TESTING
// - FixedDelay=3, valid_i=1 at cycle 0, ready_i=1 -> valid_o/ready_o high at cycle 3 only; one handshake.
// - FixedDelay=1, ready_i low in cycles 1-4 -> FSM holds Grant, handshake at cycle 5, ready_o=0 before.
// - FixedDelay=0, StallRandom=0, random traffic -> outputs bit-identical to inputs, err_o=0.
// - StallRandom=1, MaxDelay=7, 1000 beats, random ready_i:
//   - every delay in 0..7;
//   - d matches a reference LFSR model from seed 16'hACE1;
//   - beats in == beats out, order kept.
// - FixedDelay=4, payload_i changed at cycle 2 -> err_o=1 from cycle 3; beat still completes at cycle 4.
// - rst_ni pulsed low in Stall -> valid_o=ready_o=0, err_o=0; next beat starts a fresh delay of d.

Source files
------------

// File: rtl/stream_pkg.sv
// Constants shared by the stream delay blocks (source-side and sink-side):
// LFSR feedback taps, default seed and the LFSR step function.
package stream_pkg;

    // Fibonacci feedback from bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stream_accept_delay_if.sv
// One valid/ready stream with a typed payload; the master drives payload/valid.
interface stream_accept_delay_if #(
    parameter type payload_t = logic
);
    payload_t payload;
    logic     valid;
    logic     ready;

    modport master (output payload, output valid, input  ready);
    modport slave  (input  payload, input  valid, output ready);
endinterface

// File: rtl/stream_accept_delay_counter.sv
// Loadable up/down counter; priority is clear, then load, then count.
module stream_accept_delay_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else if (clear_i) begin
            r_q <= '0;
        end else if (load_i) begin
            r_q <= d_i;
        end else if (en_i) begin
            r_q <= down_i ? (r_q - WIDTH'(1)) : (r_q + WIDTH'(1));
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/stream_accept_delay.sv
// Sink-side backpressure injector: delays each upstream beat by a fixed or
// LFSR-drawn number of cycles and flags upstream changes made while stalled.
module stream_accept_delay
    import stream_pkg::*;
#(
    parameter bit          StallRandom = 1'b0,
    parameter int unsigned FixedDelay  = 1,
    parameter int unsigned MaxDelay    = 15,
    parameter logic [15:0] LfsrSeed    = LFSR_DEFAULT_SEED,
    parameter type         payload_t   = logic
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  payload_t payload_i,
    input  logic     valid_i,
    output logic     ready_o,
    output payload_t payload_o,
    output logic     valid_o,
    input  logic     ready_i,
    output logic     err_o
);

    localparam int unsigned CW          = $clog2(MaxDelay + 1);
    localparam bit          PassThrough = (FixedDelay == 0) && !StallRandom;

    if (LfsrSeed == 16'h0000) begin : g_bad_seed
        $fatal(1, "stream_accept_delay: LfsrSeed must be nonzero");
    end
    if (MaxDelay < 1 || MaxDelay > 255 || ((MaxDelay + 1) & MaxDelay) != 0) begin : g_bad_max
        $fatal(1, "stream_accept_delay: MaxDelay must be 2^k-1 with k in 1..8");
    end
    if (FixedDelay > MaxDelay) begin : g_bad_fixed
        $fatal(1, "stream_accept_delay: FixedDelay exceeds MaxDelay");
    end

    assign payload_o = payload_i;

    if (PassThrough) begin : g_pass
        assign ready_o = ready_i;
        assign valid_o = valid_i;
        assign err_o   = 1'b0;
    end else begin : g_delay
        typedef enum logic [1:0] {
            ST_IDLE  = 2'd0,
            ST_STALL = 2'd1,
            ST_GRANT = 2'd2
        } state_t;

        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] w_delay;
        logic [CW-1:0] w_cnt;
        payload_t      r_snap;
        logic          r_err;
        logic          w_load;
        logic          w_valid;
        logic          w_ready;
        logic          w_viol;

        if (StallRandom) begin : g_lfsr
            logic [15:0] r_lfsr;

            // Advances once per accepted beat so each beat draws a fresh delay.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_lfsr <= LfsrSeed;
                end else if (w_load) begin
                    r_lfsr <= lfsr_next(r_lfsr);
                end
            end

            assign w_delay = r_lfsr[CW-1:0];
        end else begin : g_fixed
            assign w_delay = CW'(FixedDelay);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_load      = 1'b0;
            w_valid     = 1'b0;
            w_ready     = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        w_load = 1'b1;
                        if (w_delay == '0) begin
                            w_valid = 1'b1;
                            w_ready = ready_i;
                            if (!ready_i) w_state_nxt = ST_GRANT;
                        end else if (w_delay == CW'(1)) begin
                            w_state_nxt = ST_GRANT;
                        end else begin
                            w_state_nxt = ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (w_cnt == CW'(1)) w_state_nxt = ST_GRANT;
                end
                ST_GRANT: begin
                    w_valid = 1'b1;
                    w_ready = ready_i;
                    if (ready_i) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // Stall cycles remaining; loaded with d-1 so Grant follows at cnt==1.
        stream_accept_delay_counter #(
            .WIDTH (CW)
        ) u_counter (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (1'b0),
            .load_i  (w_load),
            .en_i    (r_state == ST_STALL),
            .down_i  (1'b1),
            .d_i     (w_delay - CW'(1)),
            .q_o     (w_cnt)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_snap <= '0;
            end else if (w_load) begin
                r_snap <= payload_i;
            end
        end

        assign w_viol = ((r_state == ST_STALL) || (r_state == ST_GRANT)) &&
                        (!valid_i || (payload_i != r_snap));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_err <= 1'b0;
            end else if (w_viol) begin
                r_err <= 1'b1;
            end
        end

        assign ready_o = w_ready;
        assign valid_o = w_valid;
        assign err_o   = r_err;
    end

endmodule

// File: tb/tb_stream_accept_delay.sv
// Bench for stream_accept_delay: directed latency/error/reset cases on fixed-delay
// instances, pass-through equivalence, and LFSR-randomised traffic with a scoreboard.
module tb_stream_accept_delay;

    typedef logic [7:0] pl_t;

    typedef struct {
        pl_t pl;
        int  start;
        int  d;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    stream_accept_delay_if #(.payload_t(pl_t)) f3_up ();
    stream_accept_delay_if #(.payload_t(pl_t)) f3_dn ();
    stream_accept_delay_if #(.payload_t(pl_t)) f1_up ();
    stream_accept_delay_if #(.payload_t(pl_t)) f1_dn ();
    stream_accept_delay_if #(.payload_t(pl_t)) f4_up ();
    stream_accept_delay_if #(.payload_t(pl_t)) f4_dn ();
    stream_accept_delay_if #(.payload_t(pl_t)) pt_up ();
    stream_accept_delay_if #(.payload_t(pl_t)) pt_dn ();
    stream_accept_delay_if #(.payload_t(pl_t)) rd_up ();
    stream_accept_delay_if #(.payload_t(pl_t)) rd_dn ();
    logic f3_err, f1_err, f4_err, pt_err, rd_err;

    stream_accept_delay #(.StallRandom(1'b0), .FixedDelay(3), .payload_t(pl_t)) u_f3 (
        .clk_i(clk), .rst_ni(rst_n), .payload_i(f3_up.payload), .valid_i(f3_up.valid),
        .ready_o(f3_up.ready), .payload_o(f3_dn.payload), .valid_o(f3_dn.valid),
        .ready_i(f3_dn.ready), .err_o(f3_err));
    stream_accept_delay #(.StallRandom(1'b0), .FixedDelay(1), .payload_t(pl_t)) u_f1 (
        .clk_i(clk), .rst_ni(rst_n), .payload_i(f1_up.payload), .valid_i(f1_up.valid),
        .ready_o(f1_up.ready), .payload_o(f1_dn.payload), .valid_o(f1_dn.valid),
        .ready_i(f1_dn.ready), .err_o(f1_err));
    stream_accept_delay #(.StallRandom(1'b0), .FixedDelay(4), .payload_t(pl_t)) u_f4 (
        .clk_i(clk), .rst_ni(rst_n), .payload_i(f4_up.payload), .valid_i(f4_up.valid),
        .ready_o(f4_up.ready), .payload_o(f4_dn.payload), .valid_o(f4_dn.valid),
        .ready_i(f4_dn.ready), .err_o(f4_err));
    stream_accept_delay #(.StallRandom(1'b0), .FixedDelay(0), .payload_t(pl_t)) u_pt (
        .clk_i(clk), .rst_ni(rst_n), .payload_i(pt_up.payload), .valid_i(pt_up.valid),
        .ready_o(pt_up.ready), .payload_o(pt_dn.payload), .valid_o(pt_dn.valid),
        .ready_i(pt_dn.ready), .err_o(pt_err));
    stream_accept_delay #(.StallRandom(1'b1), .FixedDelay(0), .MaxDelay(7),
                          .LfsrSeed(16'hACE1), .payload_t(pl_t)) u_rd (
        .clk_i(clk), .rst_ni(rst_n), .payload_i(rd_up.payload), .valid_i(rd_up.valid),
        .ready_o(rd_up.ready), .payload_o(rd_dn.payload), .valid_o(rd_dn.valid),
        .ready_i(rd_dn.ready), .err_o(rd_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference LFSR: feedback is the parity of the tapped bit positions.
    function automatic logic [15:0] ref_lfsr_step(input logic [15:0] q);
        int unsigned taps [4] = '{15, 13, 12, 10};
        logic fb;
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ q[taps[i]];
        return {q[14:0], fb};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Randomised scoreboard: driver pushes expectations, monitor pops on downstream handshakes.
    exp_t exp_q[$];
    bit   rd_active;
    bit   rd_seen;
    int   rd_up_hs;
    int   rd_dn_hs;

    always @(negedge clk) begin
        if (rd_active) begin
            chk("rd_ready_without_valid", int'(rd_up.ready & ~rd_dn.valid), 0);
            if (rd_up.valid && rd_up.ready) rd_up_hs = rd_up_hs + 1;
            if (rd_dn.valid && !rd_seen) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected_valid", 1, 0);
                end else begin
                    chk("rd_latency", cyc - exp_q[0].start, exp_q[0].d);
                    chk("rd_delay_range", int'((cyc - exp_q[0].start) <= 7), 1);
                end
                rd_seen = 1'b1;
            end
            if (rd_dn.valid && rd_dn.ready) begin
                rd_dn_hs = rd_dn_hs + 1;
                if (exp_q.size() != 0) begin
                    chk("rd_payload", int'(rd_dn.payload), int'(exp_q[0].pl));
                    void'(exp_q.pop_front());
                end
                rd_seen = 1'b0;
            end
        end
    end

    initial begin
        int   hs;
        bit   rd_done;
        logic [15:0] lfsr_m;

        checks = 0;
        errors = 0;
        rd_active = 1'b0;
        rd_seen = 1'b0;
        rd_up_hs = 0;
        rd_dn_hs = 0;
        rst_n = 1'b0;
        f3_up.valid = 1'b0; f3_up.payload = '0; f3_dn.ready = 1'b0;
        f1_up.valid = 1'b0; f1_up.payload = '0; f1_dn.ready = 1'b0;
        f4_up.valid = 1'b0; f4_up.payload = '0; f4_dn.ready = 1'b0;
        pt_up.valid = 1'b0; pt_up.payload = '0; pt_dn.ready = 1'b0;
        rd_up.valid = 1'b0; rd_up.payload = '0; rd_dn.ready = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        next_cycle();

        @(negedge clk);
        chk("reset_f3_valid", f3_dn.valid, 0);
        chk("reset_f3_ready", f3_up.ready, 0);
        chk("reset_f4_err", f4_err, 0);
        chk("reset_rd_valid", rd_dn.valid, 0);
        next_cycle();

        // Fixed delay 3, downstream always ready: single handshake in cycle 3.
        hs = 0;
        f3_up.valid = 1'b1; f3_up.payload = 8'h5A; f3_dn.ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("f3_valid_o", f3_dn.valid, int'(c == 3));
            chk("f3_ready_o", f3_up.ready, int'(c == 3));
            if (c == 3) chk("f3_payload_o", int'(f3_dn.payload), 8'h5A);
            if (f3_up.valid && f3_up.ready) hs = hs + 1;
            next_cycle();
            if (c == 3) f3_up.valid = 1'b0;
        end
        chk("f3_handshakes", hs, 1);
        chk("f3_err", f3_err, 0);

        // Fixed delay 1, downstream ready withheld until cycle 5.
        f1_up.valid = 1'b1; f1_up.payload = 8'hC3;
        for (int c = 0; c < 8; c++) begin
            f1_dn.ready = (c == 5);
            @(negedge clk);
            chk("f1_valid_o", f1_dn.valid, int'(c >= 1 && c <= 5));
            chk("f1_ready_o", f1_up.ready, int'(c == 5));
            next_cycle();
            if (c == 5) f1_up.valid = 1'b0;
        end
        chk("f1_err", f1_err, 0);

        // Fixed delay 4, payload changed mid-stall: sticky error, beat still completes.
        f4_up.valid = 1'b1; f4_up.payload = 8'h11; f4_dn.ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) f4_up.payload = 8'h22;
            @(negedge clk);
            chk("f4_err_o", f4_err, int'(c >= 3));
            chk("f4_valid_o", f4_dn.valid, int'(c == 4));
            chk("f4_ready_o", f4_up.ready, int'(c == 4));
            next_cycle();
            if (c == 4) f4_up.valid = 1'b0;
        end

        // Reset pulsed while stalling: beat abandoned, error cleared, fresh delay of 4.
        f4_up.valid = 1'b1; f4_up.payload = 8'h33;
        for (int c = 0; c < 11; c++) begin
            if (c == 2) rst_n = 1'b0;
            if (c == 4) rst_n = 1'b1;
            @(negedge clk);
            chk("rst_valid_o", f4_dn.valid, int'(c == 8));
            chk("rst_ready_o", f4_up.ready, int'(c == 8));
            chk("rst_err_o", f4_err, int'(c < 2));
            next_cycle();
            if (c == 8) f4_up.valid = 1'b0;
        end

        // Pass-through: outputs follow inputs combinationally.
        for (int c = 0; c < 200; c++) begin
            pt_up.valid   = 1'($urandom_range(0, 1));
            pt_up.payload = 8'($urandom);
            pt_dn.ready   = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("pt_valid_o", pt_dn.valid, pt_up.valid);
            chk("pt_ready_o", pt_up.ready, pt_dn.ready);
            chk("pt_payload_o", int'(pt_dn.payload), int'(pt_up.payload));
            chk("pt_err_o", pt_err, 0);
            next_cycle();
        end

        // Random delays from the LFSR, random downstream ready, 1000 beats.
        rd_active = 1'b1;
        rd_done = 1'b0;
        lfsr_m = 16'hACE1;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    int  gap;
                    int  wait_cyc;
                    bit  got;
                    exp_t e;
                    gap = int'($urandom_range(0, 2));
                    if (gap > 0) begin
                        rd_up.valid = 1'b0;
                        repeat (gap) next_cycle();
                    end
                    e.pl  = 8'($urandom);
                    e.start = cyc;
                    e.d   = int'(lfsr_m % 16'd8);
                    lfsr_m = ref_lfsr_step(lfsr_m);
                    exp_q.push_back(e);
                    rd_up.valid = 1'b1;
                    rd_up.payload = e.pl;
                    got = 1'b0;
                    wait_cyc = 0;
                    while (!got && wait_cyc < 300) begin
                        @(negedge clk);
                        got = rd_up.ready;
                        next_cycle();
                        wait_cyc = wait_cyc + 1;
                    end
                    if (!got) chk("rd_handshake_timeout", 0, 1);
                end
                rd_up.valid = 1'b0;
                rd_done = 1'b1;
            end
            begin
                while (!rd_done) begin
                    rd_dn.ready = ($urandom_range(0, 9) < 6);
                    next_cycle();
                end
            end
        join
        repeat (3) next_cycle();
        rd_active = 1'b0;
        chk("rd_queue_empty", exp_q.size(), 0);
        chk("rd_beats_in", rd_up_hs, 1000);
        chk("rd_beats_out", rd_dn_hs, 1000);
        chk("rd_err", rd_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
